// File: rtl/uart_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module : uart_apb_sequencer
// Brief  : APB master that brings up the UART slave, then arbitrates host
//          TX-byte writes and RX-byte reads onto its APB port.
// Rev    : 1.0
// ============================================================================
module uart_apb_sequencer #(
   parameter int          TIMEOUT      = 1024,
   parameter int          TX_GAP_BAUDS = 11,
   parameter logic [31:0] CTRL_RST_VAL = 32'h6,
   parameter logic [31:0] CTRL_EN_VAL  = 32'h9
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        cfg_start,
   input  logic [31:0] cfg_baud,
   output logic        cfg_done,
   input  logic        tx_req,
   input  logic [7:0]  tx_data,
   output logic        tx_ack,
   input  logic        rx_req,
   output logic        rx_ack,
   output logic [7:0]  rx_data,
   output logic        err,
   output logic        busy,
   output logic        m_psel,
   output logic        m_penable,
   output logic        m_pwrite,
   output logic [31:0] m_paddr,
   output logic [31:0] m_pwdata,
   input  logic [31:0] m_prdata,
   input  logic        m_pready
);

   localparam logic [1:0]  c_IDLE      = 2'd0;
   localparam logic [1:0]  c_SETUP     = 2'd1;
   localparam logic [1:0]  c_ACCESS    = 2'd2;
   localparam logic [1:0]  c_SETTLE    = 2'd3;

   localparam logic [1:0]  c_STEP_BAUD = 2'd0;
   localparam logic [1:0]  c_STEP_RST  = 2'd1;
   localparam logic [1:0]  c_STEP_EN   = 2'd2;

   localparam logic [31:0] c_ADDR_CTRL = 32'h0000_0000;
   localparam logic [31:0] c_ADDR_TX   = 32'h0000_0002;
   localparam logic [31:0] c_ADDR_RX   = 32'h0000_0003;
   localparam logic [31:0] c_ADDR_BAUD = 32'h0000_0004;

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic [1:0]  r_step;
   logic        r_boot;
   logic        r_op_tx;
   logic        r_rr_rx;
   logic [31:0] r_baud;
   logic [31:0] r_settle;
   logic [31:0] r_gap;
   logic [31:0] r_wait;

   logic        w_idle;
   logic        w_start;
   logic        w_boot_next;
   logic        w_svc;
   logic        w_tx_elig;
   logic        w_rx_elig;
   logic        w_grant_rx;
   logic        w_grant_tx;
   logic        w_xfer_done;
   logic        w_abort;
   logic        w_launch;
   logic [31:0] w_baud_new;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_write;
   logic        w_prdata_unused;

   assign w_prdata_unused = ^m_prdata[31:8];

   assign w_idle      = (r_state == c_IDLE);
   assign w_start     = w_idle & cfg_start;
   assign w_boot_next = w_idle & r_boot & ~cfg_start;
   assign w_svc       = w_idle & cfg_done & ~r_boot & ~cfg_start;
   assign w_baud_new  = (cfg_baud == 32'd0) ? 32'd1 : cfg_baud;

   // The ack cycle masks its own request so a held level is not served twice.
   assign w_tx_elig   = tx_req & (r_gap == 32'd0) & ~tx_ack;
   assign w_rx_elig   = rx_req & ~rx_ack;
   assign w_grant_rx  = w_svc & w_rx_elig & (r_rr_rx | ~w_tx_elig);
   assign w_grant_tx  = w_svc & w_tx_elig & ~w_grant_rx;

   assign w_xfer_done = (r_state == c_ACCESS) & m_pready;
   assign w_abort     = (r_state == c_ACCESS) & ~m_pready & (r_wait == 32'(TIMEOUT - 1));
   assign w_launch    = w_idle & (w_next == c_SETUP);

   // State register
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_start | w_boot_next | w_grant_rx | w_grant_tx) begin
               w_next = c_SETUP;
            end
         end
         c_SETUP: begin
            w_next = c_ACCESS;
         end
         c_ACCESS: begin
            if (m_pready) begin
               w_next = (r_boot && (r_step != c_STEP_BAUD)) ? c_SETTLE : c_IDLE;
            end else if (w_abort) begin
               w_next = c_IDLE;
            end
         end
         c_SETTLE: begin
            if (r_settle == 32'd0) begin
               w_next = c_IDLE;
            end
         end
         default: w_next = c_IDLE;
      endcase
   end

   // Bus handshake outputs
   always_comb begin
      m_psel    = 1'b0;
      m_penable = 1'b0;
      busy      = 1'b1;
      case (r_state)
         c_IDLE:   busy = 1'b0;
         c_SETUP:  m_psel = 1'b1;
         c_ACCESS: begin
            m_psel    = 1'b1;
            m_penable = 1'b1;
         end
         default:  busy = 1'b1;
      endcase
   end

   // Address/data of the transfer about to be launched from IDLE
   always_comb begin
      w_addr  = c_ADDR_BAUD;
      w_wdata = w_baud_new;
      w_write = 1'b1;
      if (w_start) begin
         w_addr  = c_ADDR_BAUD;
         w_wdata = w_baud_new;
      end else if (w_boot_next) begin
         case (r_step)
            c_STEP_RST: begin
               w_addr  = c_ADDR_CTRL;
               w_wdata = CTRL_RST_VAL;
            end
            c_STEP_EN: begin
               w_addr  = c_ADDR_CTRL;
               w_wdata = CTRL_EN_VAL;
            end
            default: begin
               w_addr  = c_ADDR_BAUD;
               w_wdata = r_baud;
            end
         endcase
      end else if (w_grant_rx) begin
         w_addr  = c_ADDR_RX;
         w_wdata = 32'd0;
         w_write = 1'b0;
      end else begin
         w_addr  = c_ADDR_TX;
         w_wdata = {24'h0, tx_data};
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         m_paddr  <= 32'd0;
         m_pwdata <= 32'd0;
         m_pwrite <= 1'b0;
         r_op_tx  <= 1'b0;
         r_rr_rx  <= 1'b1;
         r_wait   <= 32'd0;
      end else begin
         if (w_launch) begin
            m_paddr  <= w_addr;
            m_pwdata <= w_wdata;
            m_pwrite <= w_write;
            r_op_tx  <= w_grant_tx;
            if (w_grant_rx | w_grant_tx) begin
               r_rr_rx <= w_grant_tx;
            end
         end
         if (r_state == c_SETUP) begin
            r_wait <= 32'd0;
         end else if (r_state == c_ACCESS) begin
            r_wait <= r_wait + 32'd1;
         end
      end
   end

   // Bring-up sequencing, service completion and sticky status
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_boot   <= 1'b0;
         r_step   <= c_STEP_BAUD;
         r_baud   <= 32'd1;
         r_settle <= 32'd0;
         r_gap    <= 32'd0;
         cfg_done <= 1'b0;
         err      <= 1'b0;
         tx_ack   <= 1'b0;
         rx_ack   <= 1'b0;
         rx_data  <= 8'd0;
      end else begin
         tx_ack <= 1'b0;
         rx_ack <= 1'b0;
         if (r_gap != 32'd0) begin
            r_gap <= r_gap - 32'd1;
         end
         if (w_start) begin
            r_baud   <= w_baud_new;
            r_boot   <= 1'b1;
            r_step   <= c_STEP_BAUD;
            cfg_done <= 1'b0;
            err      <= 1'b0;
            r_gap    <= 32'd0;
         end
         if (w_xfer_done) begin
            if (r_boot) begin
               if (r_step == c_STEP_BAUD) begin
                  r_step <= c_STEP_RST;
               end else begin
                  r_settle <= r_baud - 32'd1;
               end
            end else if (r_op_tx) begin
               tx_ack <= 1'b1;
               r_gap  <= 32'(TX_GAP_BAUDS) * r_baud - 32'd1;
            end else begin
               rx_ack  <= 1'b1;
               rx_data <= m_prdata[7:0];
            end
         end
         // A timed-out service transfer is still acknowledged so the host never stalls.
         if (w_abort) begin
            err <= 1'b1;
            if (r_boot) begin
               r_boot <= 1'b0;
               r_step <= c_STEP_BAUD;
            end else if (r_op_tx) begin
               tx_ack <= 1'b1;
            end else begin
               rx_ack <= 1'b1;
            end
         end
         if (r_state == c_SETTLE) begin
            if (r_settle == 32'd0) begin
               if (r_step == c_STEP_RST) begin
                  r_step <= c_STEP_EN;
               end else begin
                  r_boot   <= 1'b0;
                  r_step   <= c_STEP_BAUD;
                  cfg_done <= 1'b1;
               end
            end else begin
               r_settle <= r_settle - 32'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_sequencer.sv
`default_nettype none
// Directed scenario bench for uart_apb_sequencer with a simple APB slave model.
module tb_uart_apb_sequencer;

   localparam int TMO = 16;

   logic        PCLK = 1'b0;
   logic        PRESET, cfg_start, cfg_done, tx_req, tx_ack, rx_req, rx_ack;
   logic        err, busy, m_psel, m_penable, m_pwrite, m_pready;
   logic [31:0] cfg_baud, m_paddr, m_pwdata, m_prdata;
   logic [7:0]  tx_data, rx_data;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   uart_apb_sequencer #(.TIMEOUT(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .cfg_start(cfg_start), .cfg_baud(cfg_baud),
      .cfg_done(cfg_done), .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
      .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data), .err(err), .busy(busy),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
      .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   // Slave: pready held low for wait_n ACCESS cycles, or forever when stuck0.
   int          acc_cnt = 0;
   int          wait_n  = 0;
   logic        stuck0  = 1'b0;
   logic [31:0] rd_val  = 32'd0;
   always @(posedge PCLK) acc_cnt <= (m_psel && m_penable && !m_pready) ? acc_cnt + 1 : 0;
   assign m_pready = !stuck0 && (acc_cnt >= wait_n);
   assign m_prdata = rd_val;

   // Bus monitor: logs completed transfers and protocol anomalies.
   logic [31:0] lg_addr[$];
   logic [31:0] lg_wd[$];
   logic        lg_wr[$];
   int          lg_beg[$];
   int          lg_end[$];
   logic [31:0] cur_addr, cur_wd;
   logic        cur_wr;
   int          cur_beg = 0, acc_run = 0, last_acc = 0, unstable = 0, b2b = 0;
   int          n_txack = 0, n_rxack = 0, txack_cyc = 0, rxack_cyc = 0;
   logic        prev_psel = 1'b0;

   always @(negedge PCLK) begin
      if (tx_ack) begin n_txack++; txack_cyc = cyc; end
      if (rx_ack) begin n_rxack++; rxack_cyc = cyc; end
      if (m_penable && !m_psel) unstable++;
      if (m_psel && !m_penable) begin
         if (prev_psel) b2b++;
         cur_addr = m_paddr; cur_wd = m_pwdata; cur_wr = m_pwrite;
         cur_beg = cyc; acc_run = 0;
      end else if (m_psel && m_penable) begin
         acc_run++;
         last_acc = cyc;
         if (m_paddr !== cur_addr || m_pwdata !== cur_wd || m_pwrite !== cur_wr) unstable++;
         if (m_pready) begin
            lg_addr.push_back(cur_addr); lg_wd.push_back(cur_wd); lg_wr.push_back(cur_wr);
            lg_beg.push_back(cur_beg); lg_end.push_back(cyc);
         end
      end
      prev_psel = m_psel;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic clear_log();
      lg_addr.delete(); lg_wd.delete(); lg_wr.delete(); lg_beg.delete(); lg_end.delete();
      unstable = 0; b2b = 0; n_txack = 0; n_rxack = 0;
   endtask

   task automatic apply_reset();
      PRESET = 1'b1; cfg_start = 1'b0; tx_req = 1'b0; rx_req = 1'b0;
      tick(2);
      PRESET = 1'b0;
   endtask

   task automatic bringup(input logic [31:0] b);
      cfg_baud = b; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < 4 * b + 64 && !cfg_done; i++) tick();
      n_cmp++;
      if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL bringup_done: got %b want 1", cfg_done); end
   endtask

   task automatic test_reset();
      PRESET = 1'b1; cfg_start = 1'b0; cfg_baud = 32'd0; tx_req = 1'b0; tx_data = 8'd0; rx_req = 1'b0;
      tick(3);
      n_cmp++;
      if ({cfg_done, tx_ack, rx_ack, err, busy, m_psel, m_penable, m_pwrite} !== 8'd0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 00000000",
                           {cfg_done, tx_ack, rx_ack, err, busy, m_psel, m_penable, m_pwrite});
      end
      n_cmp++;
      if ({m_paddr, m_pwdata, rx_data} !== 72'd0) begin
         n_bad++; $display("FAIL reset_bus: got %h %h %h want zeros", m_paddr, m_pwdata, rx_data);
      end
      PRESET = 1'b0;
      tick(5);
      n_cmp++;
      if ({busy, m_psel} !== 2'b00) begin n_bad++; $display("FAIL reset_idle: got %b want 00", {busy, m_psel}); end
   endtask

   task automatic test_bringup(input int b);
      int s, d;
      clear_log();
      cfg_baud = b; cfg_start = 1'b1; s = cyc;
      tick();
      cfg_start = 1'b0;
      n_cmp++;
      if ({cfg_done, busy} !== 2'b01) begin n_bad++; $display("FAIL boot_started: got %b want 01", {cfg_done, busy}); end
      for (int i = 0; i < 2 * b + 100 && !cfg_done; i++) tick();
      d = cyc;
      n_cmp++;
      if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL boot_done: got %b want 1", cfg_done); end
      n_cmp++;
      if (lg_addr.size() !== 3) begin n_bad++; $display("FAIL boot_count: got %0d want 3", lg_addr.size()); end
      if (lg_addr.size() == 3) begin
         n_cmp++;
         if ({lg_addr[0], lg_wd[0], lg_addr[1], lg_wd[1], lg_addr[2], lg_wd[2]} !==
             {32'h4, b[31:0], 32'h0, 32'h6, 32'h0, 32'h9}) begin
            n_bad++; $display("FAIL boot_seq: got %h=%h %h=%h %h=%h want 4=%h 0=6 0=9", lg_addr[0], lg_wd[0],
                              lg_addr[1], lg_wd[1], lg_addr[2], lg_wd[2], b);
         end
         n_cmp++;
         if ({lg_wr[0], lg_wr[1], lg_wr[2]} !== 3'b111) begin n_bad++; $display("FAIL boot_write: got %b want 111", {lg_wr[0], lg_wr[1], lg_wr[2]}); end
         n_cmp++;
         if ((lg_end[0] - lg_beg[0]) + (lg_end[1] - lg_beg[1]) + (lg_end[2] - lg_beg[2]) !== 3) begin
            n_bad++; $display("FAIL boot_len: got %0d %0d %0d want 1 1 1", lg_end[0] - lg_beg[0], lg_end[1] - lg_beg[1], lg_end[2] - lg_beg[2]);
         end
         n_cmp++;
         if (lg_beg[0] - s !== 1) begin n_bad++; $display("FAIL boot_first: got %0d want 1", lg_beg[0] - s); end
         n_cmp++;
         if (lg_beg[1] - lg_end[0] !== 2) begin n_bad++; $display("FAIL boot_gap0: got %0d want 2", lg_beg[1] - lg_end[0]); end
         n_cmp++;
         if (lg_beg[2] - lg_end[1] !== b + 2) begin n_bad++; $display("FAIL boot_settle1: got %0d want %0d", lg_beg[2] - lg_end[1], b + 2); end
         n_cmp++;
         if (d - lg_end[2] !== b + 1) begin n_bad++; $display("FAIL boot_settle2: got %0d want %0d", d - lg_end[2], b + 1); end
      end
      n_cmp++;
      if ({unstable, b2b, 31'd0, busy} !== 64'd0) begin n_bad++; $display("FAIL boot_protocol: got %0d %0d %b want 0 0 0", unstable, b2b, busy); end
   endtask

   task automatic test_tx_rx();
      int t;
      bringup(4);
      clear_log();
      tx_data = 8'hA1; tx_req = 1'b1; t = cyc;
      for (int i = 0; i < 20 && !tx_ack; i++) tick();
      tx_req = 1'b0;
      tick(3);
      n_cmp++;
      if (n_txack !== 1) begin n_bad++; $display("FAIL tx_ack_count: got %0d want 1", n_txack); end
      n_cmp++;
      if (lg_addr.size() !== 1) begin n_bad++; $display("FAIL tx_count: got %0d want 1", lg_addr.size()); end
      if (lg_addr.size() == 1) begin
         n_cmp++;
         if ({lg_addr[0], lg_wd[0], lg_wr[0]} !== {32'h2, 32'hA1, 1'b1}) begin
            n_bad++; $display("FAIL tx_xfer: got %h %h %b want 2 a1 1", lg_addr[0], lg_wd[0], lg_wr[0]);
         end
         n_cmp++;
         if ({lg_beg[0] - t, txack_cyc - lg_end[0]} !== {32'd1, 32'd1}) begin
            n_bad++; $display("FAIL tx_timing: got %0d %0d want 1 1", lg_beg[0] - t, txack_cyc - lg_end[0]);
         end
      end
      clear_log();
      rd_val = 32'h3C5A_96A1; rx_req = 1'b1;
      for (int i = 0; i < 20 && !rx_ack; i++) tick();
      n_cmp++;
      if ({rx_ack, rx_data} !== {1'b1, 8'hA1}) begin n_bad++; $display("FAIL rx_data: got %b %h want 1 a1", rx_ack, rx_data); end
      rx_req = 1'b0;
      tick(3);
      n_cmp++;
      if ({n_rxack, 24'd0, rx_data} !== {32'd1, 24'd0, 8'hA1}) begin n_bad++; $display("FAIL rx_ack_hold: got %0d %h want 1 a1", n_rxack, rx_data); end
      if (lg_addr.size() == 1) begin
         n_cmp++;
         if ({lg_addr[0], lg_wr[0], rxack_cyc - lg_end[0]} !== {32'h3, 1'b0, 32'd1}) begin
            n_bad++; $display("FAIL rx_xfer: got %h %b %0d want 3 0 1", lg_addr[0], lg_wr[0], rxack_cyc - lg_end[0]);
         end
      end
   endtask

   task automatic test_arbitration();
      apply_reset();
      bringup(4);
      clear_log();
      rd_val = 32'h3C5A_96A1; tx_data = 8'h11; tx_req = 1'b1; rx_req = 1'b1;
      for (int i = 0; i < 20 && !rx_ack; i++) tick();
      rx_req = 1'b0;
      for (int i = 0; i < 20 && !tx_ack; i++) tick();
      tx_data = 8'h22; rx_req = 1'b1;
      for (int i = 0; i < 20 && !rx_ack; i++) tick();
      rx_req = 1'b0;
      for (int i = 0; i < 80 && !tx_ack; i++) tick();
      tx_req = 1'b0;
      tick(3);
      n_cmp++;
      if ({n_txack, n_rxack} !== {32'd2, 32'd2}) begin n_bad++; $display("FAIL arb_acks: got %0d %0d want 2 2", n_txack, n_rxack); end
      n_cmp++;
      if (lg_addr.size() !== 4) begin n_bad++; $display("FAIL arb_count: got %0d want 4", lg_addr.size()); end
      if (lg_addr.size() == 4) begin
         n_cmp++;
         if ({lg_addr[0], lg_addr[1], lg_wd[1], lg_addr[2], lg_addr[3], lg_wd[3]} !==
             {32'h3, 32'h2, 32'h11, 32'h3, 32'h2, 32'h22}) begin
            n_bad++; $display("FAIL arb_order: got %h %h=%h %h %h=%h want 3 2=11 3 2=22", lg_addr[0], lg_addr[1],
                              lg_wd[1], lg_addr[2], lg_addr[3], lg_wd[3]);
         end
         n_cmp++;
         if (lg_beg[1] - lg_end[0] !== 2) begin n_bad++; $display("FAIL arb_switch: got %0d want 2", lg_beg[1] - lg_end[0]); end
         n_cmp++;
         if (lg_beg[3] - lg_end[1] !== 45) begin n_bad++; $display("FAIL arb_tx_gap: got %0d want 45", lg_beg[3] - lg_end[1]); end
      end
      n_cmp++;
      if ({unstable, b2b} !== 64'd0) begin n_bad++; $display("FAIL arb_protocol: got %0d %0d want 0 0", unstable, b2b); end
   endtask

   task automatic test_wait_states();
      bringup(4);
      clear_log();
      wait_n = 5; tx_data = 8'h5C; tx_req = 1'b1;
      for (int i = 0; i < 40 && !tx_ack; i++) tick();
      tx_req = 1'b0;
      tick(2);
      wait_n = 0;
      n_cmp++;
      if (lg_addr.size() !== 1) begin n_bad++; $display("FAIL ws_count: got %0d want 1", lg_addr.size()); end
      if (lg_addr.size() == 1) begin
         n_cmp++;
         if ({lg_end[0] - lg_beg[0], txack_cyc - lg_end[0]} !== {32'd6, 32'd1}) begin
            n_bad++; $display("FAIL ws_timing: got %0d %0d want 6 1", lg_end[0] - lg_beg[0], txack_cyc - lg_end[0]);
         end
         n_cmp++;
         if ({lg_addr[0], lg_wd[0], unstable} !== {32'h2, 32'h5C, 32'd0}) begin
            n_bad++; $display("FAIL ws_stable: got %h %h %0d want 2 5c 0", lg_addr[0], lg_wd[0], unstable);
         end
      end
   endtask

   task automatic test_timeout();
      bringup(4);
      n_cmp++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL to_pre_err: got %b want 0", err); end
      clear_log();
      rd_val = 32'h0000_0077; stuck0 = 1'b1; rx_req = 1'b1;
      for (int i = 0; i < TMO + 20 && !rx_ack; i++) tick();
      rx_req = 1'b0;
      tick(2);
      stuck0 = 1'b0;
      n_cmp++;
      if ({err, rx_data, busy} !== {1'b1, 8'hA1, 1'b0}) begin n_bad++; $display("FAIL to_status: got %b %h %b want 1 a1 0", err, rx_data, busy); end
      n_cmp++;
      if ({acc_run, n_rxack, 32'(lg_addr.size())} !== {32'd16, 32'd1, 32'd0}) begin
         n_bad++; $display("FAIL to_abort: got %0d %0d %0d want 16 1 0", acc_run, n_rxack, lg_addr.size());
      end
      n_cmp++;
      if (rxack_cyc - last_acc !== 1) begin n_bad++; $display("FAIL to_ack_time: got %0d want 1", rxack_cyc - last_acc); end
   endtask

   task automatic test_reset_mid();
      n_cmp++;
      if ({cfg_done, err} !== 2'b11) begin n_bad++; $display("FAIL rm_pre: got %b want 11", {cfg_done, err}); end
      wait_n = 5; tx_data = 8'h33; tx_req = 1'b1;
      for (int i = 0; i < 10 && !m_penable; i++) tick();
      n_cmp++;
      if (m_penable !== 1'b1) begin n_bad++; $display("FAIL rm_access: got %b want 1", m_penable); end
      PRESET = 1'b1; tx_req = 1'b0;
      tick();
      n_cmp++;
      if ({m_psel, m_penable, cfg_done, err, busy} !== 5'd0) begin
         n_bad++; $display("FAIL rm_reset: got %b want 00000", {m_psel, m_penable, cfg_done, err, busy});
      end
      tick();
      PRESET = 1'b0; wait_n = 0;
      tick(5);
      n_cmp++;
      if ({m_psel, busy, tx_ack, rx_data} !== 11'd0) begin
         n_bad++; $display("FAIL rm_no_resume: got %b %b %b %h want 0 0 0 00", m_psel, busy, tx_ack, rx_data);
      end
   endtask

   task automatic test_boot_timeout();
      clear_log();
      stuck0 = 1'b1; cfg_baud = 32'd5; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < 40 && busy; i++) tick();
      stuck0 = 1'b0;
      tick(5);
      n_cmp++;
      if ({err, cfg_done, busy, m_psel} !== 4'b1000) begin
         n_bad++; $display("FAIL bt_status: got %b want 1000", {err, cfg_done, busy, m_psel});
      end
      n_cmp++;
      if ({acc_run, 32'(lg_addr.size())} !== {32'd16, 32'd0}) begin
         n_bad++; $display("FAIL bt_abort: got %0d %0d want 16 0", acc_run, lg_addr.size());
      end
   endtask

   task automatic test_early_req();
      apply_reset();
      clear_log();
      tx_data = 8'h7E; tx_req = 1'b1;
      tick(20);
      n_cmp++;
      if ({32'(lg_addr.size()), n_txack, 31'd0, busy} !== 96'd0) begin
         n_bad++; $display("FAIL early_hold: got %0d %0d %b want 0 0 0", lg_addr.size(), n_txack, busy);
      end
      cfg_baud = 32'd3; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < 5 && !m_psel; i++) tick();
      cfg_baud = 32'd7; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < 100 && !tx_ack; i++) tick();
      tx_req = 1'b0;
      tick(3);
      n_cmp++;
      if ({n_txack, 32'(lg_addr.size())} !== {32'd1, 32'd4}) begin
         n_bad++; $display("FAIL early_count: got %0d %0d want 1 4", n_txack, lg_addr.size());
      end
      if (lg_addr.size() == 4) begin
         n_cmp++;
         if ({lg_addr[0], lg_wd[0]} !== {32'h4, 32'h3}) begin n_bad++; $display("FAIL early_ignore: got %h=%h want 4=3", lg_addr[0], lg_wd[0]); end
         n_cmp++;
         if ({lg_beg[2] - lg_end[1], lg_beg[3] - lg_end[2]} !== {32'd5, 32'd5}) begin
            n_bad++; $display("FAIL early_timing: got %0d %0d want 5 5", lg_beg[2] - lg_end[1], lg_beg[3] - lg_end[2]);
         end
         n_cmp++;
         if ({lg_addr[3], lg_wd[3], lg_wr[3]} !== {32'h2, 32'h7E, 1'b1}) begin
            n_bad++; $display("FAIL early_tx: got %h %h %b want 2 7e 1", lg_addr[3], lg_wd[3], lg_wr[3]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bringup(10417);
      test_tx_rx();
      test_arbitration();
      test_wait_states();
      test_timeout();
      test_reset_mid();
      test_boot_timeout();
      test_early_req();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
